alu_word_seq: RTL
=================

Name: alu_word_seq

Overview:
- Parameterised WIDTH-bit ALU for the 16-bit CPU datapath, built from the bit-slice ALU's operation set.
- Adds registered results, status flags and a valid/ready handshake on both input and output.
- Adds iterative unsigned multiply (low half and high half) by shift-and-add, one bit per cycle.
- Sits between the register-file read stage and write-back; the control unit drives Op from ALUCtrl[2:0].

Parameters:
WIDTH, 16, operand/result width in bits; legal range 4..32.

Ports:
Clock  input  1  rising-edge clock.
ResetN  input  1  asynchronous active-low reset.
InValid  input  1  operands and Op are valid this cycle.
InReady  output  1  block can accept a new operation.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
CarryIn  input  1  carry into the LSB for ADD; ignored by all other ops.
AInvert  input  1  invert A before the operation; applies to all ops except MUL ops.
BInvert  input  1  invert B before the operation; applies to all ops except MUL ops; forced to 1 for SUB and SLT.
Op  input  3  000 AND, 001 SUB, 010 OR, 011 XOR, 100 ADD, 101 SLT, 110 MULLO, 111 MULHI.
OutValid  output  1  Result and flags are valid.
OutReady  input  1  consumer accepts the result.
Result  output  WIDTH  registered result.
CarryOut  output  1  adder carry out of the MSB.
Overflow  output  1  signed overflow for add/sub; high-half-nonzero indication for MULLO.
Zero  output  1  Result == 0.
Negative  output  1  Result[WIDTH-1].

Behaviour:
- Reset (ResetN low, asynchronous):
  - state = IDLE.
  - InReady=1, OutValid=0.
  - Result=0, CarryOut=0, Overflow=0, Zero=0, Negative=0.
  - Internal accumulator, multiplicand and bit counter cleared.
  - Reset asserted mid-multiply aborts the operation; no OutValid is produced for it.
- Operand conditioning:
  - mA = AInvert ? ~A : A.
  - mB = (BInvert | Op==SUB | Op==SLT) ? ~B : B.
  - Adder carry-in: 1 for SUB and SLT, CarryIn for ADD.
- States: IDLE, BUSY, DONE. InReady = (state==IDLE).
- IDLE:
  - On InValid & InReady, latch the inputs.
  - Ops 000-101: compute and register Result/flags in the same edge, go to DONE. Latency 1 cycle from acceptance to OutValid.
  - Ops 110/111: load the unsigned multiplicand A and multiplier B, clear the 2*WIDTH accumulator and counter, go to BUSY.
- BUSY:
  - Each cycle: if the multiplier LSB=1, add the multiplicand (shifted by the count) into the accumulator; shift the multiplier right; increment the counter.
  - After exactly WIDTH BUSY cycles, register the Result and go to DONE. Total latency WIDTH+1 cycles from acceptance to OutValid.
  - InValid is ignored in BUSY.
- DONE:
  - OutValid=1.
  - Result and flags stay stable until OutValid & OutReady. On that handshake go to IDLE.
  - OutReady low: hold indefinitely (backpressure). No new input is accepted while in DONE.
- Results:
  - AND = mA&mB; OR = mA|mB; XOR = mA^mB.
  - ADD/SUB = WIDTH-bit sum, discarding the carry from the Result.
  - SLT = {WIDTH-1 zeros, sum[MSB]^V}; signed compare, correct on overflow.
  - MULLO = product[WIDTH-1:0]; MULHI = product[2W-1:W].
- Flags:
  - ADD/SUB/SLT: CarryOut = adder carry; Overflow V = carry into MSB XOR carry out of MSB.
  - Logic ops: CarryOut=0, Overflow=0.
  - MULLO: CarryOut=0, Overflow = (product high half != 0).
  - MULHI: CarryOut=0, Overflow=0.
  - Zero and Negative are always derived from the registered Result.
- Input stability: A, B and Op may change after acceptance; only the latched copies are used.
- Simultaneous events: when an OutReady handshake occurs with InValid high in the same cycle, the new op is not accepted that cycle. It is accepted the next cycle, in IDLE. Throughput is at most 1 op per 2 cycles.

Test Plan:
- WIDTH=16, AND/OR/XOR with A=16'hF0F0, B=16'h0FF0: Results 16'h00F0, 16'hFFF0, 16'hFF00, OutValid one cycle after acceptance. With AInvert=BInvert=1, OR gives 16'hFF0F (NAND).
- ADD A=16'hFFFF, B=16'h0001, CarryIn=0: Result=0, CarryOut=1, Zero=1, Overflow=0. ADD A=16'h7FFF, B=1: Result 16'h8000, Overflow=1, Negative=1.
- SUB A=5, B=7: Result 16'hFFFE, CarryOut=0, Negative=1. SLT A=16'h8000, B=1: Result=1. SLT A=1, B=16'h8000: Result=0.
- MULLO A=16'h1234, B=16'h0100: Result 16'h3400, Overflow=1, OutValid exactly 17 cycles after acceptance. MULHI on the same operands: Result 16'h0012.
- Backpressure: hold OutReady=0 for 10 cycles after OutValid. Result is stable, InReady=0, a pending InValid is not accepted; release OutReady and the pending op is accepted the cycle after the handshake.
- Drop ResetN during cycle 5 of a MULLO: all outputs return to their reset values immediately. After release, a new ADD 2+3 returns 5 with no stale OutValid.

Source files
------------

// File: rtl/alu_word_seq.sv
// alu_word_seq: WIDTH-bit sequential ALU with registered result and flags and a
// valid/ready handshake on both sides. Single-cycle logic/add/sub/slt ops and an
// iterative shift-and-add unsigned multiply (one multiplier bit per cycle).
//
// Ports:
//   Clock, ResetN          rising-edge clock, asynchronous active-low reset
//   InValid / InReady      input handshake; InReady is high only in idle
//   A, B, CarryIn          operands and ADD carry-in
//   AInvert, BInvert, Op   operand conditioning and operation select
//   OutValid / OutReady    output handshake; result held until accepted
//   Result, CarryOut,
//   Overflow, Zero,
//   Negative               registered result and status flags
module alu_word_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  input  logic             AInvert,
  input  logic             BInvert,
  input  logic [2:0]       Op,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpOr  = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpAdd = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;
  logic                 neg_q, neg_d;
  logic                 mul_hi_q, mul_hi_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  // Operand conditioning and the shared adder (single-cycle ops only).
  logic                 sub_like;
  logic                 add_cin;
  logic [WIDTH-1:0]     m_a, m_b;
  logic [WIDTH:0]       sum;
  logic                 c_msb;
  logic                 v_flag;
  logic [2*WIDTH-1:0]   acc_step;
  logic                 load_res;

  always_comb begin
    sub_like = (Op == OpSub) || (Op == OpSlt);
    m_a      = AInvert ? ~A : A;
    m_b      = (BInvert || sub_like) ? ~B : B;
    add_cin  = sub_like ? 1'b1 : ((Op == OpAdd) ? CarryIn : 1'b0);
    sum      = {1'b0, m_a} + {1'b0, m_b} + {{WIDTH{1'b0}}, add_cin};
    // Carry into the MSB recovered from the MSB sum bit.
    c_msb    = m_a[WIDTH-1] ^ m_b[WIDTH-1] ^ sum[WIDTH-1];
    v_flag   = c_msb ^ sum[WIDTH];
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    mul_hi_d = mul_hi_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    load_res = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (InValid) begin
          if (Op[2:1] == 2'b11) begin
            mul_hi_d = Op[0];
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StBusy;
          end else begin
            load_res = 1'b1;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            case (Op)
              OpAnd:   result_d = m_a & m_b;
              OpOr:    result_d = m_a | m_b;
              OpXor:   result_d = m_a ^ m_b;
              OpSlt: begin
                // Sign of the true difference, corrected for overflow.
                result_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v_flag};
                carry_d  = sum[WIDTH];
                ovf_d    = v_flag;
              end
              default: begin // OpAdd, OpSub
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
                ovf_d    = v_flag;
              end
            endcase
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          load_res = 1'b1;
          result_d = mul_hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
          carry_d  = 1'b0;
          ovf_d    = !mul_hi_q && (acc_step[2*WIDTH-1:WIDTH] != '0);
          state_d  = StDone;
        end
      end
      StDone: begin
        if (OutReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Zero/Negative track the result register only when it is reloaded, so the
    // reset value of Zero stays 0 until a real result exists.
    zero_d = load_res ? (result_d == '0) : zero_q;
    neg_d  = load_res ? result_d[WIDTH-1] : neg_q;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= StIdle;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      mul_hi_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      mul_hi_q <= mul_hi_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign InReady  = (state_q == StIdle);
  assign OutValid = (state_q == StDone);
  assign Result   = result_q;
  assign CarryOut = carry_q;
  assign Overflow = ovf_q;
  assign Zero     = zero_q;
  assign Negative = neg_q;

endmodule
